// File: rtl/pwm_pkg.sv
// pwm_pkg - shared definitions for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTER : counting mode encodings (center_mode input)
//   state_t                 : top-level run state (IDLE, RUN)
//   ch_lsb()                : low bit of channel ch inside a packed per-channel bus
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_compare.sv
// pwm_compare - one PWM output bit.
//   clk, rst : clock, asynchronous active-high reset
//   cnt_i    : counter value that will be current in the next cycle
//   duty_i   : duty value D of the bank that will be active next cycle
//   pol_i    : polarity of that bank (1 = active low)
//   idle_i   : next cycle is idle, drive the inactive level
//   out_o    : registered PWM output, aligned with the registered counter
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             pol_i,
  input  logic             idle_i,
  output logic             out_o
);

  logic out_q;

  // The counter never exceeds L (edge) or Le-1 (centre), so a duty value
  // beyond that range is naturally always active without forming L+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
    end else if (idle_i) begin
      out_q <= pol_i;
    end else begin
      out_q <= (cnt_i < duty_i) ^ pol_i;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi - multi-channel PWM generator with a shared period counter.
//   clk, rst       : clock, asynchronous active-high reset
//   enable         : run when 1, hold idle when 0
//   wave_length    : period setting L
//   high_time      : per-channel duty D[i] at [i*WIDTH +: WIDTH]
//   polarity       : per-channel active-low select
//   center_mode    : 0 = edge-aligned sawtooth, 1 = centre-aligned triangle
//   update         : strobe capturing the settings into the shadow bank
//   update_pending : shadow bank holds settings not yet applied
//   out            : registered PWM outputs
//   last_cycle     : registered, high in the final cycle of each period
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          wave_length,
  input  logic [CHANNELS*WIDTH-1:0] high_time,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      center_mode,
  input  logic                      update,
  output logic                      update_pending,
  output logic [CHANNELS-1:0]       out,
  output logic                      last_cycle
);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      down_q, down_d;
  logic                      last_q, last_d;
  logic                      pending_q, pending_d;

  logic [WIDTH-1:0]          sh_len_q;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q;
  logic [CHANNELS-1:0]       sh_pol_q;
  logic                      sh_mode_q;

  logic [WIDTH-1:0]          act_len_q, act_len_d;
  logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d;
  logic [CHANNELS-1:0]       act_pol_q, act_pol_d;
  logic                      act_mode_q, act_mode_d;

  logic                      apply;
  logic                      idle_d;
  logic [WIDTH-1:0]          top_cnt;  // Le-1, turning point of the triangle

  always_comb begin
    // Shadow settings move to the active bank at a period boundary, or
    // whenever the block is (or is about to be) idle.
    apply      = pending_q && (state_q == IDLE || !enable || last_q);
    act_len_d  = apply ? sh_len_q  : act_len_q;
    act_duty_d = apply ? sh_duty_q : act_duty_q;
    act_pol_d  = apply ? sh_pol_q  : act_pol_q;
    act_mode_d = apply ? sh_mode_q : act_mode_q;

    top_cnt = (act_len_q == '0) ? '0 : act_len_q - 1'b1;

    state_d = RUN;
    cnt_d   = '0;
    down_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else if (state_q == IDLE || last_q) begin
      // start of a period: cnt 0, counting up
      state_d = RUN;
    end else if (act_mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!down_q) begin
      // the top value is held for a second cycle as the phase turns
      if (cnt_q == top_cnt) begin
        cnt_d  = cnt_q;
        down_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d  = cnt_q - 1'b1;
      down_d = 1'b1;
    end
    idle_d = (state_d == IDLE);

    if (idle_d) begin
      last_d = 1'b0;
    end else if (act_mode_d == MODE_EDGE) begin
      last_d = (cnt_d == act_len_d);
    end else begin
      last_d = down_d && (cnt_d == '0);
    end

    // a strobe on the boundary edge is captured after the old shadow moved on
    pending_d = update ? 1'b1 : (apply ? 1'b0 : pending_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      down_q     <= 1'b0;
      last_q     <= 1'b0;
      pending_q  <= 1'b0;
      sh_len_q   <= '0;
      sh_duty_q  <= '0;
      sh_pol_q   <= '0;
      sh_mode_q  <= MODE_EDGE;
      act_len_q  <= '0;
      act_duty_q <= '0;
      act_pol_q  <= '0;
      act_mode_q <= MODE_EDGE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      down_q     <= down_d;
      last_q     <= last_d;
      pending_q  <= pending_d;
      act_len_q  <= act_len_d;
      act_duty_q <= act_duty_d;
      act_pol_q  <= act_pol_d;
      act_mode_q <= act_mode_d;
      if (update) begin
        sh_len_q  <= wave_length;
        sh_duty_q <= high_time;
        sh_pol_q  <= polarity;
        sh_mode_q <= center_mode;
      end
    end
  end

  // Each channel compares the next counter value with the next active bank,
  // so the registered output lines up with the registered counter.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pwm_compare #(
        .WIDTH(WIDTH)
      ) u_cmp (
        .clk    (clk),
        .rst    (rst),
        .cnt_i  (cnt_d),
        .duty_i (act_duty_d[ch_lsb(gi, WIDTH) +: WIDTH]),
        .pol_i  (act_pol_d[gi]),
        .idle_i (idle_d),
        .out_o  (out[gi])
      );
    end
  endgenerate

  assign update_pending = pending_q;
  assign last_cycle     = last_q;

endmodule
